btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Front end for the board pushbutton feeding the lab FSM's direction input `in`.
//   - Synchronises the raw asynchronous button pin into the fast system clock domain.
//   - Rejects contact bounce by requiring a stable level for DEBOUNCE_CYCLES clocks.
//   - Outputs a clean level, plus single-cycle rise and fall pulses.
//   - btn_level drives the FSM `in`; the pulses serve edge-triggered consumers.
// PARAMETERS
//   SYNC_STAGES      2           synchroniser flop count, >=2
//   DEBOUNCE_CYCLES  1_000_000   consecutive stable clocks to accept a change (20 ms @ 50 MHz), >=2
//   LONG_CYCLES      50_000_000  clocks held high before btn_long fires (1 s @ 50 MHz), >=2
// PORTS
//   clk        in   1  system clock (undivided board clock)
//   rst        in   1  asynchronous reset, active-high
//   btn_in     in   1  raw button pin, asynchronous, 1 = pressed
//   btn_level  out  1  debounced level, registered
//   btn_rise   out  1  one-cycle pulse on accepted 0->1
//   btn_fall   out  1  one-cycle pulse on accepted 1->0
//   btn_long   out  1  one-cycle pulse on long press (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst=1):
//   - All outputs 0; synchroniser flops 0; counters 0; state IDLE_LOW.
//   - Takes effect immediately, including mid-count. Any pending change is discarded.
//   Synchroniser: btn_in passes through SYNC_STAGES flops; the last stage is `s`.
//   FSM states: IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
//   - IDLE_LOW:    s=1 -> WAIT_HIGH, cnt<=1; else stay.
//   - WAIT_HIGH:   s=0 -> IDLE_LOW, cnt<=0 (bounce, no output).
//                  s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH; btn_level<=1; btn_rise<=1 for one cycle.
//                  else cnt++.
//   - STABLE_HIGH: s=0 -> WAIT_LOW, cnt<=1; else stay.
//   - WAIT_LOW:    mirror of WAIT_HIGH. Completion -> IDLE_LOW; btn_level<=0; btn_fall<=1.
//   Latency:
//   - btn_level changes DEBOUNCE_CYCLES edges after the first edge that samples the new `s`.
//   - Total is SYNC_STAGES+DEBOUNCE_CYCLES edges from a clean btn_in step.
//   - Any reversal of `s` before completion restarts the count from the original stable state.
//   Widths and edge cases:
//   - cnt width is $clog2(DEBOUNCE_CYCLES); it never wraps because every exit clears it.
//   - btn_rise and btn_fall are never high together and never high in consecutive cycles.
//   - Glitches shorter than one clock may vanish in the synchroniser; that is acceptable.
//   - Button held through reset release: the FSM starts at IDLE_LOW, sees s=1 and runs a
//     full debounce, so btn_rise fires after SYNC_STAGES+DEBOUNCE_CYCLES edges.
// CONFIGURATION
//   Macro: BTN_LONGPRESS_EN.
//   - Defined: a second counter (width $clog2(LONG_CYCLES)) runs only in STABLE_HIGH and
//     clears on entry.
//   - When it reaches LONG_CYCLES-1, btn_long pulses once for one cycle; the counter then
//     saturates (no repeat) until the button is released.
//   - Undefined: no counter is built; btn_long is tied to constant 0. The port is always
//     present.
// STRUCTURE
//   Package btn_pkg:
//   - state enum (2-bit: IDLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3).
//   - default-timing localparams for 50 MHz.
//   Sub-module btn_sync:
//   - parameterised SYNC_STAGES flop chain with async active-high reset to 0.
//   - reusable for the other board switches.
//   The FSM, counters and pulse registers stay in btn_debounce.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
//   1. Clean press: btn_in 0->1, held 20 clk -> btn_rise high exactly 1 clk, 6 edges
//      after the step; btn_level=1 from then on.
//   2. Bounce: btn_in 1 for 3 clk, 0 for 2 clk, then 1 held -> no pulse during bounce;
//      btn_rise 6 edges after the final rise.
//   3. Release after test 1: btn_in 1->0 held -> btn_fall 1 clk at +6 edges;
//      btn_level=0; btn_rise stays 0.
//   4. Reset in WAIT_HIGH (2 clk after press): all outputs 0 immediately.
//      After rst falls with btn_in=1, btn_rise fires 6 edges later.
//   5. Long press, BTN_LONGPRESS_EN defined: hold 40 clk -> btn_long single pulse 10
//      edges after btn_rise; no repeat. Same stimulus without the macro -> btn_long
//      constant 0.
//   6. Chatter every 2 clk for 30 clk -> btn_level, btn_rise and btn_fall all stay 0.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and 50 MHz default timing for the button front end
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } btn_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button input and debounced level/pulse outputs
interface btn_debounce_if;

    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic btn_long;

    modport master (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_long
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_long
    );

endinterface

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - STAGES-deep flop chain bringing an asynchronous pin into clk
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchroniser + debouncer with level, edge and long-press outputs
// Optional long-press counter is built only when BTN_LONGPRESS_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.master bus
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("btn_debounce: SYNC_STAGES, DEBOUNCE_CYCLES and LONG_CYCLES must all be >= 2");
    end

    logic          s;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_q, level_nxt;
    logic          rise_q, rise_nxt;
    logic          fall_q, fall_nxt;

    btn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    // Every exit from a WAIT state clears cnt, so it never needs to wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;

`ifdef BTN_LONGPRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_ONE  = LW'(1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt;
    logic          long_fired;
    logic          long_q;

    // Counter saturates at LONG_LAST; long_fired blocks a repeat until the high phase ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt       <= '0;
            long_fired <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state == STABLE_HIGH && s) begin
                if (lcnt != LONG_LAST) begin
                    lcnt <= lcnt + LONG_ONE;
                end else if (!long_fired) begin
                    long_q     <= 1'b1;
                    long_fired <= 1'b1;
                end
            end else begin
                lcnt       <= '0;
                long_fired <= 1'b0;
            end
        end
    end

    assign bus.btn_long = long_q;
`else
    assign bus.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized + directed scoreboard bench for btn_debounce
module tb_btn_debounce;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LONGC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_debounce_if bus();

    btn_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONGC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [3:0] sbq[$];
    string      dn[$];
    int         da[$];
    int         de[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    function automatic logic [3:0] dut_out();
        return {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.btn_long};
    endfunction

    task automatic post(input string nm, input int act, input int exp);
        dn.push_back(nm);
        da.push_back(act);
        de.push_back(exp);
    endtask

    // Reference: the synchronised sample lags btn_in by SYNC edges; the level flips
    // once DEB consecutive samples disagree with it; long fires after LONGC-1 further
    // high samples while accepted high.
    initial begin : model
        logic m0, m1, s, lvl, prev_s, fired, r, f, l;
        int   run, hold;
        m0 = 0; m1 = 0; lvl = 0; prev_s = 0; fired = 0; run = 0; hold = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m0 = 0; m1 = 0; lvl = 0; prev_s = 0; fired = 0; run = 0; hold = 0;
                sbq.delete();
            end else begin
                cyc++;
                s  = m1;
                m1 = m0;
                m0 = bus.btn_in;
                r = 0; f = 0; l = 0;
                if (lvl && prev_s && s) begin
                    if (hold < LONGC - 1) hold++;
                    else if (!fired) begin
                        fired = 1;
                        l = 1;
                    end
                end else begin
                    hold  = 0;
                    fired = 0;
                end
`ifndef BTN_LONGPRESS_EN
                l = 0;
`endif
                if (s != lvl) begin
                    run++;
                    if (run == DEB) begin
                        lvl = ~lvl;
                        r   = lvl;
                        f   = ~lvl;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
                prev_s = s;
                sbq.push_back({lvl, r, f, l});
            end
        end
    end

    initial begin : monitor
        logic [3:0] e, a;
        string      nm;
        int         x, y;
        forever begin
            @(negedge clk);
            while (dn.size() > 0) begin
                nm = dn.pop_front();
                x  = da.pop_front();
                y  = de.pop_front();
                n_tests++;
                if (x != y) begin
                    n_fail++;
                    $display("FAIL %s: got %0d want %0d", nm, x, y);
                end
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = dut_out();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs@cyc%0d: got level/rise/fall/long=%b want %b", cyc, a, e);
                end
            end
        end
    end

    task automatic hold_btn(input logic v, input int n);
        bus.btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    // which: 0 rise, 1 fall, 2 long. Returns posedges until seen, -1 on expiry.
    task automatic edges_until(input int which, input int limit, output int n);
        logic hit;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            hit = (which == 0) ? bus.btn_rise : (which == 1) ? bus.btn_fall : bus.btn_long;
            if (hit) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         n;
        int         long_cnt;
        logic [2:0] chat;
        bus.btn_in = 1'b0;
        repeat (2) @(negedge clk);
        post("reset_state", int'(dut_out()), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // clean press
        bus.btn_in = 1'b1;
        edges_until(0, 50, n);
        post("press_latency", n, SYNC + DEB);
        @(negedge clk);
        hold_btn(1'b1, 18);
        post("level_after_press", int'(bus.btn_level), 1);

        // release
        bus.btn_in = 1'b0;
        edges_until(1, 50, n);
        post("release_latency", n, SYNC + DEB);
        @(negedge clk);
        hold_btn(1'b0, 10);
        post("level_after_release", int'(bus.btn_level), 0);

        // bounce then settle high
        hold_btn(1'b1, 3);
        hold_btn(1'b0, 2);
        bus.btn_in = 1'b1;
        edges_until(0, 50, n);
        post("bounce_latency", n, SYNC + DEB);
        @(negedge clk);
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 14);

        // reset while waiting for a rise
        bus.btn_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 post("rst_mid_count", int'(dut_out()), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        edges_until(0, 50, n);
        post("rst_release_latency", n, SYNC + DEB);
        @(negedge clk);

        // reset while accepted high
        post("level_before_rst", int'(bus.btn_level), 1);
        #2 rst = 1'b1;
        #1 post("rst_level_high", int'(dut_out()), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        bus.btn_in = 1'b0;
        @(negedge clk);
        hold_btn(1'b0, 10);

        // long press
        bus.btn_in = 1'b1;
        edges_until(0, 50, n);
        post("long_press_rise", n, SYNC + DEB);
        edges_until(2, 30, n);
`ifdef BTN_LONGPRESS_EN
        post("long_latency", n, LONGC);
`else
        post("long_absent", n, -1);
`endif
        long_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 long_cnt += int'(bus.btn_long);
        end
        post("long_no_repeat", long_cnt, 0);
        @(negedge clk);
        hold_btn(1'b0, 14);

        // chatter every 2 clocks
        chat = '0;
        for (int i = 0; i < 30; i++) begin
            bus.btn_in = ((i / 2) % 2) == 0;
            @(posedge clk);
            #1 chat = chat | {bus.btn_level, bus.btn_rise, bus.btn_fall};
            @(negedge clk);
        end
        post("chatter_quiet", int'(chat), 0);
        hold_btn(1'b0, 8);

        // randomized hold lengths straddling the debounce window
        for (int i = 0; i < 300; i++) begin
            hold_btn(1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        hold_btn(1'b0, 14);
        repeat (3) @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
